// File: rtl/can_arb_pkg.sv
// Shared types and constants for the two-master CAN register-port arbiter.
// Contents: FSM state encoding, master index constants, fixed response data
// returned on timeout and on filtered (no slave access) M0 transactions.
package can_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_M0 = 2'd1,
        ST_BUSY_M1 = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
    localparam logic [7:0] FILTER_DATA  = 8'h00;

    // One-hot grant vector for a master index (bit0 = M0, bit1 = M1).
    function automatic logic [1:0] master_onehot(input logic master);
        return master ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/can_arb_rr.sv
// Two-way round-robin picker.
// Ports:
//   req_m0_i, req_m1_i : pending requests
//   last_grant_i       : master index served most recently
//   grant_o            : one-hot winner (bit0 = M0, bit1 = M1), 0 if no request
module can_arb_rr
    import can_arb_pkg::*;
(
    input  logic       req_m0_i,
    input  logic       req_m1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req_m0_i && req_m1_i) begin
            // On a tie the master that was not served last goes next.
            grant_o = (last_grant_i == MASTER_M0) ? 2'b10 : 2'b01;
        end else if (req_m0_i) begin
            grant_o = 2'b01;
        end else if (req_m1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/can_bus_arbiter.sv
// Arbiter sharing the CAN controller's 8-bit Wishbone register port between
// the host Wishbone slave port (M0) and an internal LA-driven requester (M1).
// Ports:
//   wb_clk_i, wb_rst_i          : clock, async active-high reset
//   wbs_*                       : M0 classic Wishbone (only byte lane 0 used)
//   m1_*                        : M1 level request / single-cycle ack
//   can_*                       : CAN controller register port
//   err_clr_i, err_o            : sticky slave-timeout flag and its clear
//   grant_o                     : one-hot current owner, 0 when idle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no owner; arbitrate, latch winner, or short-circuit filtered M0
// ST_BUSY_M0 | slave cycle in progress on behalf of M0
// ST_BUSY_M1 | slave cycle in progress on behalf of M1
// ST_RESP    | one cycle; schedule the owner's ack and read data
module can_bus_arbiter
    import can_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
    parameter int          TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [7:0]  m1_addr_i,
    input  logic [7:0]  m1_wdata_i,
    output logic        m1_ack_o,
    output logic [7:0]  m1_rdata_o,
    output logic        can_cyc_o,
    output logic        can_stb_o,
    output logic        can_we_o,
    output logic [7:0]  can_adr_o,
    output logic [7:0]  can_dat_o,
    input  logic [7:0]  can_dat_i,
    input  logic        can_ack_i,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [1:0]  grant_o
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    arb_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] wdat_q, wdat_d;
    logic       we_q, we_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       can_cyc_q, can_cyc_d;
    logic       wbs_ack_q, wbs_ack_d;
    logic       m1_ack_q, m1_ack_d;
    logic [7:0] wbs_dat_q, wbs_dat_d;
    logic [7:0] m1_rdata_q, m1_rdata_d;
    logic [1:0] grant_q, grant_d;

    logic       m0_req;
    logic       m0_filtered;
    logic       ack_seen;
    logic       expired;
    logic [1:0] rr_grant;
    logic       unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    assign m0_req      = wbs_cyc_i & wbs_stb_i;
    assign m0_filtered = ((wbs_adr_i & ADDR_MASK) != BASE_ADDR) || (wbs_we_i && !wbs_sel_i[0]);
    // Slave ack only counts while our strobe is actually visible to the slave.
    assign ack_seen    = can_ack_i & can_cyc_q;
    assign expired     = (cnt_q == 8'd0);

    can_arb_rr u_rr (
        .req_m0_i     (m0_req),
        .req_m1_i     (m1_req_i),
        .last_grant_i (last_q),
        .grant_o      (rr_grant)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        err_d      = err_clr_i ? 1'b0 : err_q;
        can_cyc_d  = 1'b0;
        wbs_ack_d  = 1'b0;
        m1_ack_d   = 1'b0;
        wbs_dat_d  = wbs_dat_q;
        m1_rdata_d = m1_rdata_q;
        grant_d    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (rr_grant[0]) begin
                    owner_d = MASTER_M0;
                    if (m0_filtered) begin
                        rdata_d = FILTER_DATA;
                        state_d = ST_RESP;
                    end else begin
                        adr_d   = wbs_adr_i[7:0];
                        wdat_d  = wbs_dat_i[7:0];
                        we_d    = wbs_we_i;
                        cnt_d   = TMO_LOAD;
                        state_d = ST_BUSY_M0;
                    end
                end else if (rr_grant[1]) begin
                    owner_d = MASTER_M1;
                    adr_d   = m1_addr_i;
                    wdat_d  = m1_wdata_i;
                    we_d    = m1_we_i;
                    cnt_d   = TMO_LOAD;
                    state_d = ST_BUSY_M1;
                end
            end
            ST_BUSY_M0, ST_BUSY_M1: begin
                grant_d = master_onehot(owner_q);
                if (ack_seen) begin
                    rdata_d = can_dat_i;
                    state_d = ST_RESP;
                end else if (expired) begin
                    rdata_d = TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d     = cnt_q - 8'd1;
                    can_cyc_d = 1'b1;
                end
            end
            ST_RESP: begin
                grant_d = master_onehot(owner_q);
                if (owner_q == MASTER_M0) begin
                    wbs_ack_d = 1'b1;
                    wbs_dat_d = rdata_q;
                end else begin
                    m1_ack_d   = 1'b1;
                    m1_rdata_d = rdata_q;
                end
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            owner_q    <= MASTER_M0;
            last_q     <= MASTER_M1;
            adr_q      <= 8'd0;
            wdat_q     <= 8'd0;
            we_q       <= 1'b0;
            rdata_q    <= 8'd0;
            err_q      <= 1'b0;
            can_cyc_q  <= 1'b0;
            wbs_ack_q  <= 1'b0;
            m1_ack_q   <= 1'b0;
            wbs_dat_q  <= 8'd0;
            m1_rdata_q <= 8'd0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            can_cyc_q  <= can_cyc_d;
            wbs_ack_q  <= wbs_ack_d;
            m1_ack_q   <= m1_ack_d;
            wbs_dat_q  <= wbs_dat_d;
            m1_rdata_q <= m1_rdata_d;
            grant_q    <= grant_d;
        end
    end

    assign wbs_ack_o  = wbs_ack_q;
    assign wbs_dat_o  = {24'h00_0000, wbs_dat_q};
    assign m1_ack_o   = m1_ack_q;
    assign m1_rdata_o = m1_rdata_q;
    assign can_cyc_o  = can_cyc_q;
    assign can_stb_o  = can_cyc_q;
    assign can_we_o   = we_q;
    assign can_adr_o  = adr_q;
    assign can_dat_o  = wdat_q;
    assign err_o      = err_q;
    assign grant_o    = grant_q;

endmodule

// File: tb/tb_can_bus_arbiter.sv
// Directed self-checking bench for can_bus_arbiter (TIMEOUT = 16).
// Inputs are driven and outputs sampled on the falling clock edge. "c" counts
// falling edges after the request was applied; an output registered at rising
// edge j is first visible at c = j+1.
module tb_can_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
    logic [3:0]  wbs_sel_i = 0;
    logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        m1_req_i = 0, m1_we_i = 0;
    logic [7:0]  m1_addr_i = 0, m1_wdata_i = 0;
    logic        m1_ack_o;
    logic [7:0]  m1_rdata_o;
    logic        can_cyc_o, can_stb_o, can_we_o;
    logic [7:0]  can_adr_o, can_dat_o;
    logic [7:0]  can_dat_i = 0;
    logic        can_ack_i = 0;
    logic        err_clr_i = 0;
    logic        err_o;
    logic [1:0]  grant_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    can_bus_arbiter #(
        .BASE_ADDR (32'h3000_0000),
        .ADDR_MASK (32'hFFFF_FF00),
        .TIMEOUT   (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .m1_req_i   (m1_req_i),
        .m1_we_i    (m1_we_i),
        .m1_addr_i  (m1_addr_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_ack_o   (m1_ack_o),
        .m1_rdata_o (m1_rdata_o),
        .can_cyc_o  (can_cyc_o),
        .can_stb_o  (can_stb_o),
        .can_we_o   (can_we_o),
        .can_adr_o  (can_adr_o),
        .can_dat_o  (can_dat_o),
        .can_dat_i  (can_dat_i),
        .can_ack_i  (can_ack_i),
        .err_clr_i  (err_clr_i),
        .err_o      (err_o),
        .grant_o    (grant_o)
    );

    // Zero-wait slave stimulus: ack with data = address + 1 in the first
    // cycle the strobe is seen.
    task automatic step_slave();
        if (can_cyc_o && !can_ack_i) begin
            can_ack_i = 1'b1;
            can_dat_i = can_adr_o + 8'h01;
        end else begin
            can_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({wbs_ack_o, m1_ack_o, can_cyc_o, can_stb_o, can_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {wbs_ack_o, m1_ack_o, can_cyc_o, can_stb_o, can_we_o}); end
        checks++; if ({wbs_dat_o, m1_rdata_o, can_adr_o, can_dat_o} !== 56'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {wbs_dat_o, m1_rdata_o, can_adr_o, can_dat_o}); end
        checks++; if ({err_o, grant_o} !== 3'b000) begin errors++; $display("FAIL reset_err_grant: got %b expected 000", {err_o, grant_o}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({can_cyc_o, grant_o} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {can_cyc_o, grant_o}); end
    endtask

    task automatic test_tie_rounds();
        logic [1:0] seq [0:5];
        logic [1:0] prev;
        logic [1:0] want;
        int gi = 0;
        int n0, n1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'h1; wbs_adr_i = 32'h3000_0010;
            m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h20;
            prev = 2'b00; n0 = 0; n1 = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (grant_o != 2'b00 && prev == 2'b00) begin
                    if (gi < 6) seq[gi] = grant_o;
                    gi++;
                end
                prev = grant_o;
                checks++; if ((wbs_ack_o && m1_ack_o) !== 1'b0) begin errors++; $display("FAIL tie_dual_ack: round %0d cycle %0d both acks high", r, c); end
                if (wbs_ack_o) begin
                    n0++;
                    checks++; if (wbs_dat_o !== 32'h0000_0011) begin errors++; $display("FAIL tie_m0_data: got %h expected 00000011", wbs_dat_o); end
                    wbs_cyc_i = 0; wbs_stb_i = 0;
                end
                if (m1_ack_o) begin
                    n1++;
                    checks++; if (m1_rdata_o !== 8'h21) begin errors++; $display("FAIL tie_m1_data: got %h expected 21", m1_rdata_o); end
                    m1_req_i = 0;
                end
                step_slave();
            end
            checks++; if (n0 !== 1) begin errors++; $display("FAIL tie_m0_ack_count: round %0d got %0d expected 1", r, n0); end
            checks++; if (n1 !== 1) begin errors++; $display("FAIL tie_m1_ack_count: round %0d got %0d expected 1", r, n1); end
        end
        checks++; if (gi !== 6) begin errors++; $display("FAIL tie_grant_count: got %0d expected 6", gi); end
        for (int i = 0; i < 6 && i < gi; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (seq[i] !== want) begin errors++; $display("FAIL tie_grant_order: grant %0d got %b expected %b", i, seq[i], want); end
        end
    endtask

    task automatic test_m0_read();
        int ack_c = -1;
        int n_ack = 0;
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'h1; wbs_adr_i = 32'h3000_0005;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++; if ({can_cyc_o, can_stb_o, can_we_o} !== 3'b110) begin errors++; $display("FAIL rd_ctrl: got %b expected 110", {can_cyc_o, can_stb_o, can_we_o}); end
                checks++; if (can_adr_o !== 8'h05) begin errors++; $display("FAIL rd_addr: got %h expected 05", can_adr_o); end
                checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b expected 01", grant_o); end
            end
            if (c == 4) begin can_ack_i = 1; can_dat_i = 8'h5A; end
            if (c == 5) begin
                can_ack_i = 0; can_dat_i = 8'h00;
                checks++; if (can_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_cyc_drop: got %b expected 0", can_cyc_o); end
            end
            checks++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL rd_m1_ack: cycle %0d got 1 expected 0", c); end
            if (wbs_ack_o) begin
                n_ack++;
                if (ack_c < 0) ack_c = c;
                checks++; if (wbs_dat_o !== 32'h0000_005A) begin errors++; $display("FAIL rd_data: got %h expected 0000005a", wbs_dat_o); end
                wbs_cyc_i = 0; wbs_stb_i = 0;
            end
        end
        checks++; if (ack_c !== 6) begin errors++; $display("FAIL rd_ack_cycle: got %0d expected 6", ack_c); end
        checks++; if (n_ack !== 1) begin errors++; $display("FAIL rd_ack_pulses: got %0d expected 1", n_ack); end
        checks++; if (wbs_dat_o !== 32'h0000_005A) begin errors++; $display("FAIL rd_data_hold: got %h expected 0000005a", wbs_dat_o); end
    endtask

    task automatic test_m0_write();
        int ack_c = -1;
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'b0001;
        wbs_adr_i = 32'h3000_0033; wbs_dat_i = 32'hABCD_EF77;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++; if ({can_cyc_o, can_we_o, can_adr_o, can_dat_o} !== {2'b11, 8'h33, 8'h77}) begin errors++; $display("FAIL wr_slave: got %b/%h/%h expected 11/33/77", {can_cyc_o, can_we_o}, can_adr_o, can_dat_o); end
            end
            if (wbs_ack_o && ack_c < 0) begin
                ack_c = c;
                checks++; if (wbs_dat_o !== 32'h0000_0034) begin errors++; $display("FAIL wr_data: got %h expected 00000034", wbs_dat_o); end
                wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
            end
            step_slave();
        end
        checks++; if (ack_c !== 4) begin errors++; $display("FAIL wr_zero_wait_ack: got %0d expected 4", ack_c); end
    endtask

    task automatic test_filter_window();
        int ack_c = -1;
        int cyc_n = 0;
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'h1; wbs_adr_i = 32'h3000_0105;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (can_cyc_o) cyc_n++;
            if (wbs_ack_o && ack_c < 0) begin
                ack_c = c;
                checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL win_data: got %h expected 00000000", wbs_dat_o); end
                wbs_cyc_i = 0; wbs_stb_i = 0;
            end
            step_slave();
        end
        checks++; if (ack_c !== 2) begin errors++; $display("FAIL win_ack_cycle: got %0d expected 2", ack_c); end
        checks++; if (cyc_n !== 0) begin errors++; $display("FAIL win_no_slave: got %0d cyc cycles expected 0", cyc_n); end
    endtask

    task automatic test_filter_sel();
        int ack_c = -1;
        int cyc_n = 0;
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'b0010;
        wbs_adr_i = 32'h3000_0007; wbs_dat_i = 32'h0000_0099;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (can_cyc_o) cyc_n++;
            if (wbs_ack_o && ack_c < 0) begin
                ack_c = c;
                wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
            end
            step_slave();
        end
        checks++; if (ack_c !== 2) begin errors++; $display("FAIL sel_ack_cycle: got %0d expected 2", ack_c); end
        checks++; if (cyc_n !== 0) begin errors++; $display("FAIL sel_no_slave: got %0d cyc cycles expected 0", cyc_n); end
    endtask

    task automatic test_timeout();
        int ack_c = -1;
        @(negedge clk);
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h44;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 16) begin checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", err_o); end end
            if (c == 17) begin checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", err_o); end end
            if (m1_ack_o && ack_c < 0) begin
                ack_c = c;
                checks++; if (m1_rdata_o !== 8'hFF) begin errors++; $display("FAIL tmo_data: got %h expected ff", m1_rdata_o); end
                m1_req_i = 0;
            end
        end
        checks++; if (ack_c !== 18) begin errors++; $display("FAIL tmo_ack_cycle: got %0d expected 18", ack_c); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b expected 1", err_o); end
        err_clr_i = 1;
        @(negedge clk);
        err_clr_i = 0;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", err_o); end
    endtask

    task automatic test_ack_last();
        int ack_c = -1;
        @(negedge clk);
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h55;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 16) begin
                checks++; if (can_cyc_o !== 1'b1) begin errors++; $display("FAIL last_cyc_live: got %b expected 1", can_cyc_o); end
                can_ack_i = 1; can_dat_i = 8'h3C;
            end
            if (c == 17) begin can_ack_i = 0; can_dat_i = 8'h00; end
            if (m1_ack_o && ack_c < 0) begin
                ack_c = c;
                checks++; if (m1_rdata_o !== 8'h3C) begin errors++; $display("FAIL last_data: got %h expected 3c", m1_rdata_o); end
                m1_req_i = 0;
            end
        end
        checks++; if (ack_c !== 18) begin errors++; $display("FAIL last_ack_cycle: got %0d expected 18", ack_c); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL last_no_err: got %b expected 0", err_o); end
    endtask

    task automatic test_timeout_vs_clear();
        int ack_c = -1;
        @(negedge clk);
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h66;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 16) err_clr_i = 1;
            if (c == 17) begin
                err_clr_i = 0;
                checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clr_race_err: got %b expected 1", err_o); end
            end
            if (m1_ack_o && ack_c < 0) begin
                ack_c = c;
                checks++; if (m1_rdata_o !== 8'hFF) begin errors++; $display("FAIL clr_race_data: got %h expected ff", m1_rdata_o); end
                m1_req_i = 0;
            end
        end
        checks++; if (ack_c !== 18) begin errors++; $display("FAIL clr_race_ack_cycle: got %0d expected 18", ack_c); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] first = 2'b00;
        int n0 = 0;
        int n1 = 0;
        @(negedge clk);
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h77;
        repeat (3) @(negedge clk);
        checks++; if ({grant_o, can_cyc_o} !== 3'b101) begin errors++; $display("FAIL rstmid_busy: got %b expected 101", {grant_o, can_cyc_o}); end
        rst = 1;
        #1;
        checks++; if ({can_cyc_o, can_stb_o, can_we_o, grant_o, err_o, wbs_ack_o, m1_ack_o} !== 8'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 00000000", {can_cyc_o, can_stb_o, can_we_o, grant_o, err_o, wbs_ack_o, m1_ack_o}); end
        checks++; if ({can_adr_o, can_dat_o, m1_rdata_o, wbs_dat_o} !== 56'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", {can_adr_o, can_dat_o, m1_rdata_o, wbs_dat_o}); end
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'h1; wbs_adr_i = 32'h3000_0008;
        @(negedge clk);
        rst = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (grant_o != 2'b00 && first == 2'b00) first = grant_o;
            if (wbs_ack_o) begin n0++; wbs_cyc_i = 0; wbs_stb_i = 0; end
            if (m1_ack_o) begin n1++; m1_req_i = 0; end
            step_slave();
        end
        checks++; if (first !== 2'b01) begin errors++; $display("FAIL rstmid_first_grant: got %b expected 01", first); end
        checks++; if ({n0, n1} !== {32'd1, 32'd1}) begin errors++; $display("FAIL rstmid_acks: got m0=%0d m1=%0d expected 1/1", n0, n1); end
    endtask

    initial begin
        test_reset();
        test_tie_rounds();
        test_m0_read();
        test_m0_write();
        test_filter_window();
        test_filter_sel();
        test_timeout();
        test_ack_last();
        test_timeout_vs_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/can_bus_arbiter.md
# can_bus_arbiter

Two-master arbiter sharing the CAN controller's 8-bit Wishbone register port between the Caravel host Wishbone slave port (M0) and an internal requester driven from the logic-analyzer core (M1). Sits in `user_proj` between the host bus and the CAN controller. It provides:
- round-robin arbitration;
- address-window filtering for M0;
- a bounded slave-response timeout, so a hung CAN port can never stall the host bus.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, M0 window base.
- `ADDR_MASK`, 32'hFFFF_FF00, M0 address bits compared against `BASE_ADDR`.
- `TIMEOUT`, 16, slave cycles allowed before forced completion (2..255).

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset; asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  M0 classic Wishbone controls.
- `wbs_sel_i`  in  4  M0 byte lanes; only bit 0 is meaningful.
- `wbs_adr_i`  in  32  M0 address.
- `wbs_dat_i`  in  32  M0 write data; bits [7:0] are used.
- `wbs_ack_o`  out  1  M0 ack.
- `wbs_dat_o`  out  32  M0 read data; [31:8] are always 0.
- `m1_req_i`, `m1_we_i`  in  1 each  M1 request, level-held until ack.
- `m1_addr_i`, `m1_wdata_i`  in  8 each  M1 address and write data.
- `m1_ack_o`  out  1  M1 completion pulse.
- `m1_rdata_o`  out  8  M1 read data.
- `can_cyc_o`, `can_stb_o`, `can_we_o`  out  1 each  slave controls.
- `can_adr_o`, `can_dat_o`  out  8 each  slave address and write data.
- `can_dat_i`  in  8  slave read data.
- `can_ack_i`  in  1  slave ack.
- `err_clr_i`  in  1  clears `err_o`.
- `err_o`  out  1  sticky timeout flag.
- `grant_o`  out  2  one-hot current owner (bit0 = M0, bit1 = M1), 0 when idle.

## Operation
- **M0 request:** `wbs_cyc_i & wbs_stb_i`.
- **M0 in-window:** `(wbs_adr_i & ADDR_MASK) == BASE_ADDR`. The slave address is `wbs_adr_i[7:0]`.
- **M1 request:** `m1_req_i`. M1 is always in-window.
- **FSM states:** IDLE, BUSY_M0, BUSY_M1, RESP.
- **IDLE:**
  - Pick a requester: a single requester wins outright. On a tie, the master not granted last wins; `last_grant` resets to M1, so M0 wins the first tie.
  - M0 goes straight to RESP with rdata 8'h00 and no slave access if it is out-of-window, or if it is a write with `wbs_sel_i[0]==0`.
  - Otherwise the winner's address, data and we are latched, and the FSM enters BUSY_x.
- **BUSY_x:**
  - `can_cyc_o = can_stb_o = 1`; address, data and we come from the latch.
  - The timeout counter increments each cycle.
  - On `can_ack_i`: latch `can_dat_i`, go to RESP.
  - On count == `TIMEOUT-1` without ack: latch 8'hFF, set `err_o`, go to RESP.
  - If ack and expiry coincide, ack wins and `err_o` is not set.
- **RESP:** one cycle. The owner's ack is 1 and its rdata is valid; slave cyc/stb are 0. Update `last_grant`, then return to IDLE.
- **Ack and data rules:**
  - `wbs_ack_o` and `m1_ack_o` are single-cycle pulses.
  - `wbs_dat_o`/`m1_rdata_o` hold the last latched value between transactions.
  - The non-owner's ack is never asserted.
- **Request withdrawal:** a master dropping its request while BUSY does not abort the slave cycle; the RESP ack is still issued.
- **`err_o`:** sticky. `err_clr_i` clears it; a timeout in the same cycle as `err_clr_i` wins, so `err_o` is set.
- **Reset (any time, including mid-transaction):**
  - FSM → IDLE, counter = 0, `last_grant` = M1.
  - All outputs are 0, including data outputs and `err_o`.
  - An in-flight slave cycle is abandoned.

## Timing
- All outputs are registered, with no combinational input→output paths.
- **Slave access:** request sampled in IDLE at edge 0 → slave cyc/stb high from edge 1. Slave ack sampled at edge k → master ack high for the cycle after edge k+1.
- **Zero-wait slave** (`can_ack_i` in the first BUSY cycle): master ack at edge 3, measured from request sampled at edge 0.
- **Filtered M0 access:** IDLE → RESP, ack at edge 1.
- **Timeout:** master ack exactly `TIMEOUT+1` cycles after BUSY entry.
- **Back-to-back:** minimum 1 IDLE cycle between transactions. A requester held high is re-arbitrated in that IDLE cycle.

## Structure
- Package `can_arb_pkg`: state enum (IDLE, BUSY_M0, BUSY_M1, RESP), master-index constants, and the `TIMEOUT_DATA` (8'hFF) and `FILTER_DATA` (8'h00) constants.
- Sub-module `can_arb_rr`: 2-way round-robin picker. Inputs are the two requests plus `last_grant`; the output is a one-hot grant.
- The FSM, latches and timeout counter stay in the top module.

## Test plan
- **M0 read, slave acks 2 cycles after stb:** `wbs_adr_i`=32'h3000_0005, `can_dat_i`=8'h5A → `can_adr_o`=8'h05, `wbs_dat_o`=32'h0000_005A, a single `wbs_ack_o` pulse, `grant_o`=01 during BUSY.
- **Simultaneous M0 and M1 requests, repeated 3 times** (both held until acked): grants go M0, M1, M0, M1, M0, M1, with exactly one ack per master per round.
- **M0 out-of-window:** `wbs_adr_i`=32'h3000_0105 → `wbs_ack_o` one cycle after sampling, rdata 0, `can_cyc_o` never asserts.
- **M0 write with `wbs_sel_i`=4'b0010:** no slave access, ack issued.
- **Slave never acks, `TIMEOUT`=16:** M1 ack arrives 17 cycles after BUSY entry, `m1_rdata_o`=8'hFF, `err_o`=1 and stays 1; an `err_clr_i` pulse clears it.
- **Ack on the last timeout cycle:** data is the slave's value and `err_o` stays 0.
- **`wb_rst_i` asserted mid-BUSY_M1:** all outputs 0 immediately; after release, M0 wins a tie.
